// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS32 MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
// In: clk, rst_n, start, md_op, op1, op2, cancel. Out: busy, done, div_zero, hi, lo.

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mul_div_unit #(
    parameter int W      = `WORD_WIDTH,
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   md_op,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic         cancel,
    output logic         busy,
    output logic         done,
    output logic         div_zero,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int N  = W / UNROLL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, nstate;

    logic [CW-1:0]  cnt;
    // mul: {accumulator, multiplier}; div: {remainder, dividend/quotient}
    logic [2*W-1:0] p;
    // multiplicand or divisor magnitude
    logic [W-1:0]   d;
    logic           is_div;
    logic           neg_q;
    logic           neg_r;
    logic           dz;

    logic           accept;
    logic           accept_md;
    logic           accept_mt;
    logic           is_signed;
    logic           op_div;
    logic           op2_zero;
    logic [W-1:0]   mag1;
    logic [W-1:0]   mag2;

    assign accept    = start && !cancel && (state == IDLE);
    assign accept_md = accept && !md_op[2];
    assign accept_mt = accept && (md_op[2:1] == 2'b10);
    assign op_div    = md_op[1];
    assign is_signed = !md_op[0];
    assign op2_zero  = (op2 == '0);
    assign mag1      = (is_signed && op1[W-1]) ? -op1 : op1;
    assign mag2      = (is_signed && op2[W-1]) ? -op2 : op2;
    assign busy      = (state != IDLE);

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: begin
                if (accept_md)
                    nstate = (op_div && op2_zero) ? FIX : CALC;
            end
            CALC: begin
                if (cancel)
                    nstate = IDLE;
                else if (cnt == CW'(N - 1))
                    nstate = FIX;
            end
            FIX:     nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nstate;
    end

    // UNROLL shift-add or restoring-divide steps per cycle
    logic [2*W-1:0] step_p;
    logic [W:0]     sum;
    logic [W:0]     t;
    logic           ge;

    always_comb begin
        step_p = p;
        sum    = '0;
        t      = '0;
        ge     = 1'b0;
        for (int u = 0; u < UNROLL; u++) begin
            if (!is_div) begin
                sum    = {1'b0, step_p[2*W-1:W]}
                       + (step_p[0] ? {1'b0, d} : '0);
                step_p = {sum, step_p[W-1:1]};
            end else begin
                t  = {step_p[2*W-1:W], step_p[W-1]};
                ge = (t >= {1'b0, d});
                if (ge)
                    t = t - {1'b0, d};
                step_p = {t[W-1:0], step_p[W-2:0], ge};
            end
        end
    end

    logic [W-1:0] fix_hi;
    logic [W-1:0] fix_lo;

    always_comb begin
        fix_hi = p[2*W-1:W];
        fix_lo = p[W-1:0];
        if (!dz && !is_div && neg_q)
            {fix_hi, fix_lo} = -p;
        if (!dz && is_div) begin
            if (neg_q)
                fix_lo = -p[W-1:0];
            if (neg_r)
                fix_hi = -p[2*W-1:W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            p        <= '0;
            d        <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_md) begin
                cnt    <= '0;
                is_div <= op_div;
                neg_q  <= is_signed && (op1[W-1] ^ op2[W-1]);
                neg_r  <= is_signed && op_div && op1[W-1];
                dz     <= op_div && op2_zero;
                if (op_div) begin
                    d <= mag2;
                    // zero divisor: result is preloaded and CALC is skipped
                    if (op2_zero)
                        p <= {op1, {W{1'b1}}};
                    else
                        p <= {{W{1'b0}}, mag1};
                end else begin
                    d <= mag1;
                    p <= {{W{1'b0}}, mag2};
                end
            end else if (state == CALC) begin
                p   <= step_p;
                cnt <= cnt + CW'(1);
            end
            if (state == FIX && !cancel) begin
                hi       <= fix_hi;
                lo       <= fix_lo;
                div_zero <= dz;
                done     <= 1'b1;
            end
            if (accept_mt) begin
                if (md_op[0])
                    lo <= op1;
                else
                    hi <= op1;
                div_zero <= 1'b0;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random checks of mul_div_unit at UNROLL 1, 2, 4.
// Three instances share inputs; results are compared to hand values and a model.

module tb_mul_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         cancel;
    logic [2:0]   md_op;
    logic [W-1:0] op1;
    logic [W-1:0] op2;

    logic         busy_v [3];
    logic         done_v [3];
    logic         dz_v   [3];
    logic [W-1:0] hi_v   [3];
    logic [W-1:0] lo_v   [3];

    int           n_cmp = 0;
    int           n_bad = 0;

    int           lat   [3];
    int           ndone [3];
    logic [W-1:0] rhi   [3];
    logic [W-1:0] rlo   [3];
    logic         rdz   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        mul_div_unit #(
            .W      (W),
            .UNROLL ((g == 0) ? 1 : (g == 1) ? 2 : 4)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start),
            .md_op    (md_op),
            .op1      (op1),
            .op2      (op2),
            .cancel   (cancel),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .div_zero (dz_v[g]),
            .hi       (hi_v[g]),
            .lo       (lo_v[g])
        );
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one start pulse, then 40 cycles of observation on all instances;
    // a second start is raised at cycle 'again' (0 = never)
    task automatic run(input logic [2:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input int again);
        for (int i = 0; i < 3; i++) begin
            lat[i]   = 0;
            ndone[i] = 0;
            rhi[i]   = '0;
            rlo[i]   = '0;
            rdz[i]   = 1'b0;
        end
        @(negedge clk);
        start = 1'b1;
        md_op = op;
        op1   = a;
        op2   = b;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == again);
            for (int i = 0; i < 3; i++) begin
                if (done_v[i]) begin
                    ndone[i]++;
                    if (lat[i] == 0) begin
                        lat[i] = k;
                        rhi[i] = hi_v[i];
                        rlo[i] = lo_v[i];
                        rdz[i] = dz_v[i];
                    end
                end
            end
        end
        start = 1'b0;
    endtask

    function automatic logic [63:0] model(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        model = '0;
        case (op)
            3'd0: model = 64'(longint'(sa) * longint'(sb));
            3'd1: model = {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0)
                    model = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    model = {32'h0, 32'h8000_0000};
                else
                    model = {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 0)
                    model = {a, 32'hFFFF_FFFF};
                else
                    model = {a % b, a / b};
            end
        endcase
    endfunction

    int          nd;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] ex;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        md_op  = '0;
        op1    = '0;
        op2    = '0;
        repeat (2) @(negedge clk);
        check("rst_ctl", {busy_v[0], done_v[0], dz_v[0]}, 0);
        check("rst_hl", {hi_v[0], lo_v[0]}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(3'd0, 32'hFFFF_FFFE, 32'h3, 0);
        check("mult_lat_u1", lat[0], 34);
        check("mult_lat_u2", lat[1], 18);
        check("mult_lat_u4", lat[2], 10);
        check("mult_ndone", ndone[0], 1);
        for (int i = 0; i < 3; i++)
            check($sformatf("mult_hl%0d", i), {rhi[i], rlo[i]},
                  64'hFFFF_FFFF_FFFF_FFFA);

        run(3'd1, 32'hFFFF_FFFE, 32'h3, 0);
        check("multu_hl", {rhi[0], rlo[0]}, 64'h0000_0002_FFFF_FFFA);

        run(3'd2, 32'hFFFF_FFF9, 32'h2, 0);
        check("div_hl", {rhi[0], rlo[0]}, 64'hFFFF_FFFF_FFFF_FFFD);
        check("div_dz", rdz[0], 0);

        run(3'd3, 32'h7, 32'h2, 0);
        check("divu_hl", {rhi[0], rlo[0]}, 64'h0000_0001_0000_0003);

        run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf_hl", {rhi[0], rlo[0]}, 64'h0000_0000_8000_0000);
        check("div_ovf_dz", rdz[0], 0);

        run(3'd3, 32'h1234, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dz_lat%0d", i), lat[i], 2);
            check($sformatf("dz_hl%0d", i), {rhi[i], rlo[i]},
                  64'h0000_1234_FFFF_FFFF);
            check($sformatf("dz_flag%0d", i), rdz[i], 1);
        end

        run(3'd1, 32'd5, 32'd6, 5);
        check("busy_start_ndone", ndone[0], 1);
        check("busy_start_ndone4", ndone[2], 1);
        check("busy_start_lo", rlo[0], 30);
        check("busy_start_dz", rdz[0], 0);

        @(negedge clk);
        start = 1'b1;
        md_op = 3'd0;
        op1   = 32'd3;
        op2   = 32'd4;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        for (int i = 0; i < 3; i++)
            check($sformatf("cancel_busy%0d", i), busy_v[i], 0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                if (done_v[i])
                    nd++;
        end
        check("cancel_ndone", nd, 0);
        check("cancel_hl", {hi_v[0], lo_v[0]}, 64'd30);

        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        md_op  = 3'd4;
        op1    = 32'hDEAD_BEEF;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        check("cs_busy", busy_v[0], 0);
        check("cs_hi", hi_v[0], 0);
        @(negedge clk);
        check("cs_done", done_v[0], 0);

        start = 1'b1;
        md_op = 3'd4;
        op1   = 32'hA5A5_A5A5;
        @(negedge clk);
        check("mthi_done", done_v[0], 1);
        check("mthi_busy", busy_v[0], 0);
        check("mthi_hi", hi_v[0], 32'hA5A5_A5A5);
        md_op = 3'd5;
        op1   = 32'h5A5A_5A5A;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_done", done_v[0], 1);
        check("mtlo_busy", busy_v[0], 0);
        check("mtlo_hl", {hi_v[0], lo_v[0]}, 64'hA5A5_A5A5_5A5A_5A5A);
        check("mtlo_dz", dz_v[0], 0);
        @(negedge clk);
        check("mt_done_end", done_v[0], 0);

        start = 1'b1;
        md_op = 3'd6;
        op1   = 32'h1;
        @(negedge clk);
        start = 1'b0;
        nd    = 0;
        repeat (5) begin
            if (done_v[0] || busy_v[0])
                nd++;
            @(negedge clk);
        end
        check("op6_ignored", nd, 0);
        check("op6_hl", {hi_v[0], lo_v[0]}, 64'hA5A5_A5A5_5A5A_5A5A);

        start = 1'b1;
        md_op = 3'd2;
        op1   = 32'd100;
        op2   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctl", {busy_v[0], done_v[0], dz_v[0]}, 0);
        check("arst_hl", {hi_v[0], lo_v[0]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd    = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_v[0])
                nd++;
        end
        check("arst_ndone", nd, 0);

        for (int j = 0; j < 24; j++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (j % 3 == 1)
                rb = 32'($urandom_range(1, 20));
            if (j % 4 == 2)
                rb = -rb;
            if (j % 8 == 7)
                rb = '0;
            ex = model(rop, ra, rb);
            run(rop, ra, rb, 0);
            for (int i = 0; i < 3; i++) begin
                check($sformatf("swp%0d_n%0d", j, i), ndone[i], 1);
                check($sformatf("swp%0d_hl%0d", j, i),
                      {rhi[i], rlo[i]}, ex);
                check($sformatf("swp%0d_dz%0d", j, i), rdz[i],
                      64'(rop[1] && rb == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS32 execute stage; owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU over several cycles, processing UNROLL bits per cycle; MTHI/MTLO write HI/LO directly.
- Sits beside the combinational ALU. The pipeline stalls on busy and consumes hi/lo when done pulses.
- The flush (cancel) input aborts an in-flight operation on exceptions or branch squash.

Parameters:
- W, `WORD_WIDTH (32), operand and HI/LO width; must be divisible by UNROLL.
- UNROLL, 1, result bits produced per iteration cycle; legal values 1, 2, 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- start  input  1  request; accepted when start=1, busy=0, cancel=0.
- md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are ignored (no accept).
- op1  input  W  multiplicand, dividend, or MTHI/MTLO data.
- op2  input  W  multiplier or divisor.
- cancel  input  1  abort; wins over start in the same cycle.
- busy  output  1  high while an operation is in flight.
- done  output  1  single-cycle pulse when HI/LO have been updated.
- div_zero  output  1  valid with done: the last divide had divisor 0.
- hi  output  W  HI register.
- lo  output  W  LO register.

Behaviour:
- Reset (async, rst_n=0): busy=0, done=0, div_zero=0, hi=0, lo=0; FSM goes to IDLE. Any in-flight operation is dropped with no done.
- FSM states: IDLE -> CALC -> FIX -> IDLE.
- Accept edge (IDLE, start=1, cancel=0, md_op is 0-3):
  - Operands are latched.
  - Signed ops convert to magnitudes and record the result signs.
  - Next state is CALC; busy=1 from the following cycle.
- CALC:
  - Lasts N = W/UNROLL cycles; an iteration counter runs 0..N-1.
  - Multiply: shift-add, UNROLL bits per cycle, into a 2W-bit accumulator.
  - Divide: restoring division, UNROLL quotient bits per cycle.
- FIX:
  - Lasts 1 cycle and applies sign correction.
  - At the end of FIX: hi/lo are written and busy drops to 0.
  - done=1 and div_zero are valid in the following cycle, for exactly one cycle.
- Total latency: accept edge to done high is N+2 cycles (34 for W=32, UNROLL=1). The next start may be accepted in the cycle done is high.
- Multiply results: {hi,lo} = full 2W-bit product.
  - MULT: signed x signed.
  - MULTU: unsigned x unsigned.
- Divide results: lo = quotient, hi = remainder.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - DIVU is fully unsigned.
- Boundary cases:
  - DIV of -2^(W-1) by -1: lo = -2^(W-1) (wraps), hi = 0, div_zero=0.
  - Divisor 0 (DIV or DIVU): CALC is skipped and FIX runs in the cycle after accept, giving latency 2. Result is lo = all ones, hi = op1, div_zero=1.
- MTHI/MTLO:
  - Accepted in IDLE; hi (or lo) = op1 at the accept edge, and the other register is unchanged.
  - busy stays 0; done pulses the next cycle with div_zero=0.
- Start rules:
  - start while busy=1 is ignored; there is no queueing.
  - start with md_op 6 or 7 is ignored; no done is produced.
- cancel:
  - In CALC or FIX: returns to IDLE at the next edge; busy=0 and no done.
  - hi, lo and div_zero keep their pre-operation values.
  - In IDLE: suppresses acceptance of any start in that cycle.
- A cancel asserted in the done cycle has no effect on the already-written hi/lo.
- hi/lo change only on the completion edge, the MTHI/MTLO edge, or reset. They never show partial values.

Test Plan:
- MULT op1=0xFFFFFFFE (-2), op2=0x00000003 -> done 34 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV op1=-7 (0xFFFFFFF9), op2=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU op1=7, op2=2 -> lo=3, hi=1.
- Boundary divides:
  - DIV op1=0x80000000, op2=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
  - DIVU op1=0x1234, op2=0 -> done 2 cycles after accept; lo=0xFFFFFFFF, hi=0x1234, div_zero=1.
- Handshake:
  - A second start during busy is ignored, and exactly one done is seen.
  - cancel on cycle 10 of a MULT -> busy=0 next cycle, no done, hi/lo keep prior values.
  - cancel and start together in IDLE -> no accept.
- MTHI op1=0xA5A5A5A5 then MTLO op1=0x5A5A5A5A on consecutive cycles -> each done pulses 1 cycle later; hi=0xA5A5A5A5, lo=0x5A5A5A5A, busy stays 0 throughout.
- Reset and parameter checks:
  - rst_n pulled low mid-DIV -> all outputs 0 immediately (async), no done after release.
  - With UNROLL=4, the MULT case in scenario 1 gives done 10 cycles after accept with identical hi/lo.
  - A random signed/unsigned sweep against a reference model at UNROLL=1, 2 and 4 matches.
